// File: rtl/adc_capture_ctrl_pkg.sv
// adc_capture_ctrl_pkg: state encoding and fixed timing constants shared by the
// ADC capture sequencer and its bench.
package adc_capture_ctrl_pkg;

    // ADC ready path has a 3-stage synchronizer; one extra cycle of margin.
    localparam int FLUSH_CYCLES = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARM     = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_FLUSH   = 3'd3,
        ST_DONE    = 3'd4
    } capture_state_t;

endpackage

// File: rtl/adc_capture_timer.sv
// adc_capture_timer: reloadable down-counter; expired is high once `cycles`
// run cycles have elapsed since the last reload.
module adc_capture_timer #(
    parameter int cycles = 4096
) (
    input  logic clk,
    input  logic rst_n,
    input  logic reload,
    input  logic run,
    output logic expired
);

    localparam int cw = $clog2(cycles + 1);
    localparam logic [cw-1:0] reload_val = cw'(cycles - 1);

    logic [cw-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (reload) begin
            cnt <= reload_val;
        end else if (run && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/adc_capture_ctrl.sv
// adc_capture_ctrl: drives the ADC enable and writes a programmed number of samples
// into the sample buffer. Optional macro ADC_CTRL_DECIMATE_EN adds the decim input.
module adc_capture_ctrl
    import adc_capture_ctrl_pkg::*;
#(
    parameter int dw             = 8,
    parameter int aw             = 10,
    parameter int timeout_cycles = 4096
) (
    input  logic           wb_clk,
    input  logic           wb_rst_n,
    input  logic           start,
    input  logic           abort,
    input  logic [aw:0]    sample_count,
    input  logic [aw-1:0]  base_addr,
    input  logic [dw-1:0]  adc_data,
    input  logic           adc_data_ready,
    output logic           adc_enable,
    output logic           buf_we,
    output logic [aw-1:0]  buf_addr,
    output logic [dw-1:0]  buf_wdata,
    output logic           busy,
    output logic           done,
    output logic           timeout_err,
    output logic [aw:0]    captured,
    output capture_state_t dbg_state
`ifdef ADC_CTRL_DECIMATE_EN
    ,
    input  logic [3:0]     decim
`endif
);

    // Buffer write port: buf_we is a one-cycle strobe with no back-pressure; the
    // buffer must take buf_addr/buf_wdata in every cycle buf_we is high.

    localparam logic [aw:0]   max_count  = {1'b1, {aw{1'b0}}};
    localparam int            fw         = $clog2(FLUSH_CYCLES);
    localparam logic [fw-1:0] flush_load = fw'(FLUSH_CYCLES - 1);

    capture_state_t state;
    logic [aw:0]    count_q;
    logic [aw:0]    count_clamped;
    logic [aw-1:0]  base_q;
    logic [fw-1:0]  flush_cnt;
    logic           completed;
    logic           take;
    logic           timer_reload;
    logic           timer_run;
    logic           timer_expired;

    assign count_clamped = (sample_count > max_count) ? max_count : sample_count;
    assign dbg_state     = state;

`ifdef ADC_CTRL_DECIMATE_EN
    logic [3:0] decim_q;
    logic [3:0] skip_cnt;

    // First strobe of a run is always written, then every (decim+1)th.
    assign take = adc_data_ready && (skip_cnt == 4'd0);

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            decim_q  <= 4'd0;
            skip_cnt <= 4'd0;
        end else if (state == ST_IDLE && start) begin
            decim_q  <= decim;
            skip_cnt <= 4'd0;
        end else if (state == ST_CAPTURE && adc_data_ready) begin
            skip_cnt <= (skip_cnt == 4'd0) ? decim_q : skip_cnt - 1'b1;
        end
    end
`else
    assign take = adc_data_ready;
`endif

    // Any strobe, written or not, proves the ADC is alive.
    assign timer_reload = (state == ST_ARM) || (state == ST_CAPTURE && adc_data_ready);
    assign timer_run    = (state == ST_CAPTURE);

    adc_capture_timer #(
        .cycles (timeout_cycles)
    ) u_timer (
        .clk     (wb_clk),
        .rst_n   (wb_rst_n),
        .reload  (timer_reload),
        .run     (timer_run),
        .expired (timer_expired)
    );

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state       <= ST_IDLE;
            count_q     <= '0;
            base_q      <= '0;
            flush_cnt   <= '0;
            completed   <= 1'b0;
            adc_enable  <= 1'b0;
            buf_we      <= 1'b0;
            buf_addr    <= '0;
            buf_wdata   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            captured    <= '0;
        end else begin
            buf_we <= 1'b0;
            done   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (sample_count == '0) begin
                            done <= 1'b1;
                        end else begin
                            count_q     <= count_clamped;
                            base_q      <= base_addr;
                            captured    <= '0;
                            timeout_err <= 1'b0;
                            completed   <= 1'b0;
                            busy        <= 1'b1;
                            state       <= ST_ARM;
                        end
                    end
                end
                ST_ARM: begin
                    if (abort) begin
                        flush_cnt <= flush_load;
                        state     <= ST_FLUSH;
                    end else begin
                        adc_enable <= 1'b1;
                        state      <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (take) begin
                        buf_we    <= 1'b1;
                        buf_wdata <= adc_data;
                        buf_addr  <= base_q + captured[aw-1:0];
                        captured  <= captured + 1'b1;
                    end
                    // Abort wins over completion: a coincident final strobe is
                    // still written but the run does not report done.
                    if (abort) begin
                        adc_enable <= 1'b0;
                        flush_cnt  <= flush_load;
                        state      <= ST_FLUSH;
                    end else if (take && (captured + 1'b1) == count_q) begin
                        completed  <= 1'b1;
                        adc_enable <= 1'b0;
                        flush_cnt  <= flush_load;
                        state      <= ST_FLUSH;
                    end else if (!adc_data_ready && timer_expired) begin
                        timeout_err <= 1'b1;
                        adc_enable  <= 1'b0;
                        flush_cnt   <= flush_load;
                        state       <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt == '0) begin
                        busy <= 1'b0;
                        if (completed) begin
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        flush_cnt <= flush_cnt - 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// tb_adc_capture_ctrl: table-driven and randomized capture runs checked cycle by
// cycle against a behavioural capture model, plus reset / zero-count sequences.
module tb_adc_capture_ctrl;
    import adc_capture_ctrl_pkg::*;

    localparam int DW   = 8;
    localparam int AW   = 10;
    localparam int TO   = 16;
    localparam int MAXC = 1200;

    localparam int K_NONE    = 0;
    localparam int K_DONE    = 1;
    localparam int K_TIMEOUT = 2;
    localparam int K_ABORT   = 3;

    typedef struct {
        int count;
        int base;
        int first;
        int gap;
        int nstb;
        int abort_c;
        int extra_start;
        int decim;
        int exp_kind;      // -1: not tabled
        int exp_captured;  // -1: not tabled
    } vec_t;

    logic           wb_clk;
    logic           wb_rst_n;
    logic           start;
    logic           abort;
    logic [AW:0]    sample_count;
    logic [AW-1:0]  base_addr;
    logic [DW-1:0]  adc_data;
    logic           adc_data_ready;
    logic           adc_enable;
    logic           buf_we;
    logic [AW-1:0]  buf_addr;
    logic [DW-1:0]  buf_wdata;
    logic           busy;
    logic           done;
    logic           timeout_err;
    logic [AW:0]    captured;
    capture_state_t dbg_state;
`ifdef ADC_CTRL_DECIMATE_EN
    logic [3:0]     decim;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int run_id = 0;
    int prev_captured = 0;
    bit prev_timeout = 1'b0;

    logic [AW+DW-1:0] exp_q[$];
    bit               stb [MAXC];
    bit               acc [MAXC];
    logic [DW-1:0]    dat [MAXC];

    adc_capture_ctrl #(
        .dw             (DW),
        .aw             (AW),
        .timeout_cycles (TO)
    ) dut (
        .wb_clk         (wb_clk),
        .wb_rst_n       (wb_rst_n),
        .start          (start),
        .abort          (abort),
        .sample_count   (sample_count),
        .base_addr      (base_addr),
        .adc_data       (adc_data),
        .adc_data_ready (adc_data_ready),
        .adc_enable     (adc_enable),
        .buf_we         (buf_we),
        .buf_addr       (buf_addr),
        .buf_wdata      (buf_wdata),
        .busy           (busy),
        .done           (done),
        .timeout_err    (timeout_err),
        .captured       (captured),
        .dbg_state      (dbg_state)
`ifdef ADC_CTRL_DECIMATE_EN
        ,
        .decim          (decim)
`endif
    );

    // Clock / reset
    initial wb_clk = 1'b0;
    always #5 wb_clk = ~wb_clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s run %0d cycle %0d: got %0h expected %0h", name, run_id, c, act, exp);
        end
    endtask

    function automatic vec_t mk(int count, int base, int first, int gap, int nstb,
                                int abort_c, int extra_start, int decim_v, int kind, int cap);
        vec_t v;
        v.count = count; v.base = base; v.first = first; v.gap = gap; v.nstb = nstb;
        v.abort_c = abort_c; v.extra_start = extra_start; v.decim = decim_v;
        v.exp_kind = kind; v.exp_captured = cap;
        return v;
    endfunction

    // One capture: cycle 0 carries the start pulse; a strobe in cycle c >= 2 is seen in
    // CAPTURE. The model ends the run at the cycle where count is met, abort arrives,
    // or TO strobe-free cycles have passed; FLUSH then lasts 4 cycles.
    task automatic run_vec(input vec_t v, input bit rand_gaps);
        int eff, n, last, end_c, kind, sidx, run_len, cap_run, extra, cc;
        logic [AW+DW-1:0] w;
        logic [AW-1:0] a;

        run_id++;
        foreach (stb[i]) begin
            stb[i] = 1'b0;
            acc[i] = 1'b0;
            dat[i] = DW'($urandom_range(0, 255));
        end
        cc = v.first;
        for (int i = 0; i < v.nstb; i++) begin
            if (cc < MAXC) stb[cc] = 1'b1;
            cc += rand_gaps ? $urandom_range(1, 20) : v.gap;
        end

        eff = (v.count > (1 << AW)) ? (1 << AW) : v.count;
        n = 0; last = 1; end_c = -1; kind = K_NONE; sidx = 0;
        exp_q.delete();
        if (v.abort_c == 1) begin
            end_c = 1;
            kind = K_ABORT;
        end else begin
            for (int c = 2; c < MAXC - 10; c++) begin
                if (stb[c]) begin
                    if ((sidx % (v.decim + 1)) == 0) begin
                        acc[c] = 1'b1;
                        a = AW'((v.base + n) % (1 << AW));
                        exp_q.push_back({a, dat[c]});
                        n++;
                    end
                    sidx++;
                    last = c;
                end
                if (v.abort_c == c) begin
                    end_c = c; kind = K_ABORT;
                end else if (acc[c] && n == eff) begin
                    end_c = c; kind = K_DONE;
                end else if (!stb[c] && (c - last) >= TO) begin
                    end_c = c; kind = K_TIMEOUT;
                end
                if (end_c >= 0) break;
            end
        end
        if (end_c < 0) begin
            n_cmp++; n_err++;
            $display("FAIL model_horizon run %0d: no end cycle found", run_id);
            return;
        end
        extra = (v.extra_start >= 1 && v.extra_start <= end_c + 4) ? v.extra_start : -1;
        run_len = end_c + 8;
        cap_run = 0;

        for (int c = 0; c < run_len; c++) begin
            @(negedge wb_clk);
            if (c == 0) begin
                chk("idle_state", c, 32'(dbg_state), 32'(ST_IDLE));
                chk("captured_prev", c, 32'(captured), prev_captured);
                chk("timeout_prev", c, 32'(timeout_err), 32'(prev_timeout));
            end else begin
                chk("captured", c, 32'(captured), cap_run);
                chk("timeout_err", c, 32'(timeout_err), 32'(kind == K_TIMEOUT && c > end_c));
            end
            chk("busy", c, 32'(busy), 32'(c >= 1 && c <= end_c + 4));
            chk("adc_enable", c, 32'(adc_enable), 32'(c >= 2 && c <= end_c));
            chk("done", c, 32'(done), 32'(kind == K_DONE && c == end_c + 5));
            chk("buf_we", c, 32'(buf_we), 32'(c >= 1 && acc[c-1]));
            if (buf_we) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL write_extra run %0d cycle %0d: got addr %0h data %0h expected no write",
                             run_id, c, buf_addr, buf_wdata);
                end else begin
                    w = exp_q.pop_front();
                    chk("write_addr", c, 32'(buf_addr), 32'(w[AW+DW-1:DW]));
                    chk("write_data", c, 32'(buf_wdata), 32'(w[DW-1:0]));
                end
            end
            if (acc[c]) cap_run++;

            start          = (c == 0) || (c == extra);
            sample_count   = (c == 0) ? (AW+1)'(v.count) : (AW+1)'($urandom_range(0, 2047));
            base_addr      = (c == 0) ? AW'(v.base) : AW'($urandom_range(0, 1023));
            abort          = (c == v.abort_c);
            adc_data_ready = stb[c];
            adc_data       = dat[c];
`ifdef ADC_CTRL_DECIMATE_EN
            decim          = (c == 0) ? 4'(v.decim) : 4'($urandom_range(0, 15));
`endif
        end

        chk("writes_left", run_len, exp_q.size(), 0);
        if (v.exp_captured >= 0) begin
            chk("tbl_captured", run_len, 32'(captured), v.exp_captured);
            chk("tbl_timeout", run_len, 32'(timeout_err), 32'(v.exp_kind == K_TIMEOUT));
        end
        prev_captured = n;
        prev_timeout  = (kind == K_TIMEOUT);
    endtask

    initial begin
        vec_t tbl[$];
        vec_t rv;

        //        count  base   first gap nstb abort extra dec kind       cap
        tbl.push_back(mk(8,    'h3FC, 2,  5,  8,   -1,   -1,  0, K_DONE,    8));
        tbl.push_back(mk(4,    'h010, 3,  3,  2,   -1,   -1,  0, K_TIMEOUT, 2));
        tbl.push_back(mk(10,   'h100, 2,  4,  10,  10,   -1,  0, K_ABORT,   3));
        tbl.push_back(mk(1,    'h3FF, 5,  1,  3,   -1,   -1,  0, K_DONE,    1));
        tbl.push_back(mk(2047, 'h200, 2,  1,  1030,-1,   -1,  0, K_DONE,    1024));
        tbl.push_back(mk(5,    'h055, 1,  2,  6,   -1,   -1,  0, K_DONE,    5));
        tbl.push_back(mk(6,    'h0C0, 2,  2,  3,   1,    -1,  0, K_ABORT,   0));
        tbl.push_back(mk(6,    'h0A0, 2,  3,  6,   -1,   4,   0, K_DONE,    6));
        tbl.push_back(mk(3,    'h300, 2,  16, 3,   -1,   -1,  0, K_DONE,    3));
        tbl.push_back(mk(3,    'h301, 2,  17, 3,   -1,   -1,  0, K_TIMEOUT, 1));
        tbl.push_back(mk(1,    'h002, 17, 1,  1,   -1,   -1,  0, K_DONE,    1));
`ifdef ADC_CTRL_DECIMATE_EN
        tbl.push_back(mk(3,    'h040, 2,  2,  9,   -1,   -1,  2, K_DONE,    3));
`endif

        wb_rst_n = 1'b0;
        start = 1'b0; abort = 1'b0; sample_count = '0; base_addr = '0;
        adc_data = '0; adc_data_ready = 1'b0;
`ifdef ADC_CTRL_DECIMATE_EN
        decim = 4'd0;
`endif
        repeat (3) @(negedge wb_clk);
        chk("rst_adc_enable", 0, 32'(adc_enable), 0);
        chk("rst_buf_we", 0, 32'(buf_we), 0);
        chk("rst_buf_addr", 0, 32'(buf_addr), 0);
        chk("rst_buf_wdata", 0, 32'(buf_wdata), 0);
        chk("rst_busy", 0, 32'(busy), 0);
        chk("rst_done", 0, 32'(done), 0);
        chk("rst_timeout", 0, 32'(timeout_err), 0);
        chk("rst_captured", 0, 32'(captured), 0);
        chk("rst_state", 0, 32'(dbg_state), 32'(ST_IDLE));
        wb_rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], 1'b0);

        for (int i = 0; i < 14; i++) begin
            rv = mk($urandom_range(1, 20), $urandom_range(0, 1023), $urandom_range(1, 6), 1,
                    $urandom_range(0, 25), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 60) : -1,
                    ($urandom_range(0, 1) == 0) ? $urandom_range(2, 10) : -1, 0, -1, -1);
`ifdef ADC_CTRL_DECIMATE_EN
            rv.decim = $urandom_range(0, 3);
`endif
            run_vec(rv, 1'b1);
        end

        // Zero-count start: immediate done, no enable, stays idle.
        @(negedge wb_clk);
        start = 1'b1; sample_count = '0; base_addr = AW'(5);
        @(negedge wb_clk);
        start = 1'b0;
        chk("z_done", 1, 32'(done), 1);
        chk("z_busy", 1, 32'(busy), 0);
        chk("z_state", 1, 32'(dbg_state), 32'(ST_IDLE));
        for (int c = 2; c < 6; c++) begin
            @(negedge wb_clk);
            chk("z_done_off", c, 32'(done), 0);
            chk("z_adc_enable", c, 32'(adc_enable), 0);
            chk("z_busy_off", c, 32'(busy), 0);
        end

        // Asynchronous reset while a write is on the port.
        @(negedge wb_clk);
        start = 1'b1; sample_count = (AW+1)'(8); base_addr = AW'('h123);
        @(negedge wb_clk);
        start = 1'b0;
        @(negedge wb_clk);
        adc_data_ready = 1'b1; adc_data = 8'hA5;
        @(posedge wb_clk);
        #2;
        adc_data_ready = 1'b0;
        chk("mr_we_before", 0, 32'(buf_we), 1);
        chk("mr_enable_before", 0, 32'(adc_enable), 1);
        wb_rst_n = 1'b0;
        #1;
        chk("mr_adc_enable", 0, 32'(adc_enable), 0);
        chk("mr_busy", 0, 32'(busy), 0);
        chk("mr_buf_we", 0, 32'(buf_we), 0);
        chk("mr_captured", 0, 32'(captured), 0);
        chk("mr_state", 0, 32'(dbg_state), 32'(ST_IDLE));
        @(negedge wb_clk);
        wb_rst_n = 1'b1;
        repeat (2) @(negedge wb_clk);
        chk("mr_idle_after", 0, 32'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
